// File: rtl/mem_access_stage_pkg.sv
// Shared types and constants for the memory-access pipeline stage.
package mem_access_stage_pkg;

  localparam int unsigned GPR_NUM     = 32;
  localparam int unsigned GPR_ADDR_W  = $clog2(GPR_NUM);
  localparam int unsigned SINGLE_WORD = 32;

  // Load-mode one-hot carried through to write-back for load extraction.
  localparam int unsigned LOAD_SEL = 5;
  localparam int unsigned LS_LB    = 0;
  localparam int unsigned LS_LBU   = 1;
  localparam int unsigned LS_LH    = 2;
  localparam int unsigned LS_LHU   = 3;
  localparam int unsigned LS_LW    = 4;

  // Access-size encodings shared by the pipeline and the data bus.
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StIssue = 2'd1,
    StReady = 2'd2
  } mem_state_e;

endpackage

// File: rtl/store_align.sv
// Store lane steering: byte strobes and replicated write data per access size.
module store_align
  import mem_access_stage_pkg::*;
(
  input  logic [1:0]             size,
  input  logic [1:0]             addr,
  input  logic [SINGLE_WORD-1:0] rt,
  output logic [3:0]             wstrb,
  output logic [SINGLE_WORD-1:0] wdata
);

  // Replicate the source lane so the slave picks bytes purely by strobe.
  always_comb begin
    wstrb = 4'b1111;
    wdata = rt;
    case (size)
      SIZE_BYTE: begin
        wstrb = 4'b0001 << addr;
        wdata = {4{rt[7:0]}};
      end
      SIZE_HALF: begin
        wstrb = 4'b0011 << addr;
        wdata = {2{rt[15:0]}};
      end
      default: begin
        wstrb = 4'b1111;
        wdata = rt;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage: holds the EXE result, issues the data-bus address phase
// and hands the instruction to write-back once that phase is accepted.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  // Accepted requests still awaiting data_data_ok; legal values are 1 and 2.
  parameter int unsigned MAX_OUTSTANDING = 1
) (
  input  logic                   clk,
  input  logic                   rst,

  input  logic                   EXE_valid_w_i,
  input  logic                   WB_allowin_w_i,
  output logic                   MEM_allowin_w_o,
  output logic                   MEM_valid_w_o,
  input  logic                   flush_w_i,

  input  logic [GPR_ADDR_W-1:0]  EXE_writeNum_i,
  input  logic                   EXE_memReq_i,
  input  logic                   EXE_memWrite_i,
  input  logic [1:0]             EXE_memSize_i,
  input  logic [SINGLE_WORD-1:0] EXE_VAddr_i,
  input  logic [SINGLE_WORD-1:0] EXE_PAddr_i,
  input  logic [SINGLE_WORD-1:0] EXE_finalRes_i,
  input  logic [SINGLE_WORD-1:0] EXE_rtData_i,
  input  logic [LOAD_SEL-1:0]    EXE_loadSel_i,
  input  logic                   EXE_exceptionRisk_i,
  input  logic                   EXE_isDangerous_i,

  output logic [GPR_ADDR_W-1:0]  MEM_writeNum_o,
  output logic                   MEM_exceptionRisk_o,
  output logic                   MEM_memReq_o,
  output logic [SINGLE_WORD-1:0] MEM_VAddr_o,
  output logic                   MEM_isDangerous_o,
  output logic [SINGLE_WORD-1:0] MEM_finalRes_o,
  output logic [SINGLE_WORD-1:0] MEM_rtData_o,
  output logic [1:0]             MEM_alignCheck_o,
  output logic [LOAD_SEL-1:0]    MEM_loadSel_o,
  output logic [GPR_ADDR_W-1:0]  MEM_writeNum_w_o,

  output logic                   data_req,
  output logic                   data_wr,
  output logic [1:0]             data_size,
  output logic [SINGLE_WORD-1:0] data_addr,
  output logic [SINGLE_WORD-1:0] data_wdata,
  output logic [3:0]             data_wstrb,
  input  logic                   data_addr_ok,
  input  logic                   data_data_ok
);

  mem_state_e             state_q;
  logic [1:0]             out_cnt_q;

  logic [SINGLE_WORD-1:0] paddr_q;
  logic                   mem_write_q;
  logic [1:0]             mem_size_q;

  logic                   load_en;
  logic                   clear_en;
  logic                   issue_new;
  logic                   cnt_full;
  logic                   addr_hs;
  logic [3:0]             strb_raw;
  logic [SINGLE_WORD-1:0] wdata_raw;

  assign MEM_allowin_w_o = (state_q == StEmpty) || ((state_q == StReady) && WB_allowin_w_i);
  assign MEM_valid_w_o   = (state_q == StReady);

  assign load_en   = MEM_allowin_w_o && EXE_valid_w_i;
  assign clear_en  = (MEM_allowin_w_o && !EXE_valid_w_i) || flush_w_i;
  // Excepting instructions never touch the bus; they go straight to READY.
  assign issue_new = EXE_memReq_i && !EXE_exceptionRisk_i;
  assign cnt_full  = (out_cnt_q == 2'(MAX_OUTSTANDING));
  assign addr_hs   = data_req && data_addr_ok;

  // Request is a pure function of registered state, so reset drops it at once
  // and it cannot glitch while waiting for addr_ok.
  assign data_req   = (state_q == StIssue) && !cnt_full;
  assign data_addr  = paddr_q;
  assign data_size  = mem_size_q;
  assign data_wr    = mem_write_q;
  assign data_wdata = wdata_raw;
  assign data_wstrb = mem_write_q ? strb_raw : 4'b0000;

  assign MEM_alignCheck_o = MEM_VAddr_o[1:0];
  assign MEM_writeNum_w_o = MEM_writeNum_o;

  store_align u_store_align (
    .size  (mem_size_q),
    .addr  (paddr_q[1:0]),
    .rt    (MEM_rtData_o),
    .wstrb (strb_raw),
    .wdata (wdata_raw)
  );

  // Stage FSM: EMPTY -> ISSUE/READY on load, ISSUE -> READY on addr_ok; flush wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StEmpty;
    end else if (flush_w_i) begin
      state_q <= StEmpty;
    end else begin
      case (state_q)
        StEmpty: begin
          if (EXE_valid_w_i) state_q <= issue_new ? StIssue : StReady;
        end
        StIssue: begin
          if (addr_hs) state_q <= StReady;
        end
        StReady: begin
          if (WB_allowin_w_i) begin
            if (EXE_valid_w_i) state_q <= issue_new ? StIssue : StReady;
            else               state_q <= StEmpty;
          end
        end
        default: state_q <= StEmpty;
      endcase
    end
  end

  // Outstanding-request counter; accepted requests survive a flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_cnt_q <= 2'd0;
    end else begin
      case ({addr_hs, data_data_ok})
        2'b10:   out_cnt_q <= out_cnt_q + 2'd1;
        2'b01:   if (out_cnt_q != 2'd0) out_cnt_q <= out_cnt_q - 2'd1;
        default: out_cnt_q <= out_cnt_q;
      endcase
    end
  end

  // Stage register: clear beats load so a flush never captures a new instruction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      MEM_writeNum_o      <= '0;
      MEM_exceptionRisk_o <= 1'b0;
      MEM_memReq_o        <= 1'b0;
      MEM_VAddr_o         <= '0;
      MEM_isDangerous_o   <= 1'b0;
      MEM_finalRes_o      <= '0;
      MEM_rtData_o        <= '0;
      MEM_loadSel_o       <= '0;
      paddr_q             <= '0;
      mem_write_q         <= 1'b0;
      mem_size_q          <= 2'd0;
    end else if (clear_en) begin
      MEM_writeNum_o      <= '0;
      MEM_exceptionRisk_o <= 1'b0;
      MEM_memReq_o        <= 1'b0;
      MEM_VAddr_o         <= '0;
      MEM_isDangerous_o   <= 1'b0;
      MEM_finalRes_o      <= '0;
      MEM_rtData_o        <= '0;
      MEM_loadSel_o       <= '0;
      paddr_q             <= '0;
      mem_write_q         <= 1'b0;
      mem_size_q          <= 2'd0;
    end else if (load_en) begin
      MEM_writeNum_o      <= EXE_writeNum_i;
      MEM_exceptionRisk_o <= EXE_exceptionRisk_i;
      MEM_memReq_o        <= EXE_memReq_i;
      MEM_VAddr_o         <= EXE_VAddr_i;
      MEM_isDangerous_o   <= EXE_isDangerous_i;
      MEM_finalRes_o      <= EXE_finalRes_i;
      MEM_rtData_o        <= EXE_rtData_i;
      MEM_loadSel_o       <= EXE_loadSel_i;
      paddr_q             <= EXE_PAddr_i;
      mem_write_q         <= EXE_memWrite_i;
      mem_size_q          <= EXE_memSize_i;
    end
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Pipeline stage between execute and write-back. It latches the EXE result, drives the SRAM-like data bus (request/address handshake, byte strobes, store-data replication) and forwards the register-write bundle and load-select information to write-back. Load data itself returns on `data_rdata` while the instruction sits in write-back, so this stage releases an instruction once its address phase is accepted.

## Interface
Parameters:
- `MAX_OUTSTANDING`, default 1: accepted requests whose `data_data_ok` is still pending. Legal values are 1 and 2.

Ports (clock and reset first):
- `clk`  in  1  stage clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `EXE_valid_w_i`  in  1  EXE holds a valid instruction.
- `WB_allowin_w_i`  in  1  write-back accepts this cycle.
- `MEM_allowin_w_o`  out  1  this stage accepts from EXE.
- `MEM_valid_w_o`  out  1  instruction is ready for write-back.
- `flush_w_i`  in  1  exception/eret flush: kill the held instruction.
- `EXE_writeNum_i`  in  5  destination register; 0 means no write.
- `EXE_memReq_i`, `EXE_memWrite_i`  in  1 each  load/store request; store flag.
- `EXE_memSize_i`  in  2  0 = byte, 1 = half, 2 = word.
- `EXE_VAddr_i`, `EXE_PAddr_i`, `EXE_finalRes_i`, `EXE_rtData_i`  in  32 each.
- `EXE_loadSel_i`  in  `LOAD_SEL`  load-mode one-hot.
- `EXE_exceptionRisk_i`, `EXE_isDangerous_i`  in  1 each.
- `MEM_*_o` (writeNum, exceptionRisk, memReq, VAddr, isDangerous, finalRes, rtData, alignCheck[1:0], loadSel)  out  registered copies going to write-back.
- `MEM_writeNum_w_o`  out  5  forwarding/hazard number for ID.
- `data_req`, `data_wr`  out  1 each;  `data_size`  out  2;  `data_addr`, `data_wdata`  out  32;  `data_wstrb`  out  4.
- `data_addr_ok`, `data_data_ok`  in  1 each.

## Operation
- **Stage register.** Loads when `MEM_allowin_w_o && EXE_valid_w_i`. It clears when `MEM_allowin_w_o && !EXE_valid_w_i`, or on `flush_w_i`.
- **FSM states:**
  - EMPTY: no instruction held.
  - ISSUE: `data_req` = 1, waiting for `data_addr_ok`.
  - READY: result is valid for write-back.
- **FSM transitions:**
  - From EMPTY on load: go to ISSUE if `memReq && !exceptionRisk`, otherwise go to READY.
  - ISSUE to READY on `data_addr_ok`.
  - From READY when `WB_allowin_w_i`: go to EMPTY, or directly to the next state if a new instruction loads in the same cycle.
- **Outstanding-request counter.** Increments on `data_req && data_addr_ok`. Decrements on `data_data_ok`. Both events in the same cycle leave it unchanged.
  - `data_req` is gated low while the counter equals `MAX_OUTSTANDING`.
- **Valid/allowin.** `MEM_valid_w_o` = (state == READY). `MEM_allowin_w_o` = EMPTY, or READY with `WB_allowin_w_i`.
- **Bus drive.** `data_addr` = PAddr. `data_size` = memSize. `data_wr` = memWrite.
- **Write strobe.** byte: `4'b0001 << addr[1:0]`; half: `4'b0011 << addr[1:0]`; word: `4'b1111`. Loads drive `data_wstrb` = 0.
- **Write data.** byte: `{4{rt[7:0]}}`; half: `{2{rt[15:0]}}`; word: `rt`.
- **Alignment.** `MEM_alignCheck_o` = VAddr[1:0]. Misaligned accesses are flagged upstream via exceptionRisk and never reach the bus.
- **Flush.**
  - In ISSUE with `addr_ok` not yet seen: drop the request (`data_req` falls the next cycle) and go to EMPTY.
  - A request already accepted stays counted until its `data_ok`.

## Timing
- **Reset values.** Every output and all state are 0: state EMPTY, counter 0, `data_req` 0, `MEM_valid_w_o` 0. `MEM_allowin_w_o` is 1 after reset.
- **Latency.**
  - Non-memory instruction: 1 cycle, EXE → READY.
  - Memory instruction: 1 + N cycles, where N is the number of cycles until `addr_ok`. `addr_ok` in the first ISSUE cycle gives READY one cycle later.
- **Bus stability.** `data_req`, address, size, wr, wstrb and wdata stay stable from assertion until `addr_ok`.
- **Full pipe.** READY plus a stalled write-back holds all outputs and issues no new request.
- **Priority.** Flush beats update. Reset mid-request drops `data_req` asynchronously.

## Structure
- **Shared package** holds: `LOAD_SEL` width and bit indices, `GPR_NUM`, `SINGLE_WORD`, size encodings, and FSM state constants.
- **One sub-module:** `store_align` (combinational). Inputs: size, addr[1:0], rt. Outputs: wstrb, wdata.

## Test plan
- **Non-memory ALU op.** finalRes = 0x12345678, writeNum = 3, WB allowin held → `MEM_valid_w_o` the next cycle; outputs carry 0x12345678 and 3; `data_req` stays 0.
- **Store byte.** PAddr = 0x1F00_0003, rt = 0xAB, `addr_ok` delayed 2 cycles → wstrb 4'b1000, wdata 0xABABABAB; `data_req` held 3 cycles, valid one cycle after `addr_ok`.
- **Load half.** Addr 0x...02 → wstrb 0, size 1, alignCheck 2'b10, loadSel passed through.
- **Back-to-back loads, `MAX_OUTSTANDING` = 1.** The second load's `data_req` stays low until the first `data_data_ok`; the counter never exceeds 1.
- **Flush in ISSUE before `addr_ok`.** Request withdrawn, state EMPTY, `MEM_valid_w_o` never asserted.
- **Write-back stall.** `WB_allowin_w_i` = 0 for 4 cycles with READY held → outputs frozen, `MEM_allowin_w_o` = 0, no bus activity.
